dct_transpose: RTL and testbench
================================

DCT_TRANSPOSE -- requirements
Module: dct_transpose

Interface
REQ-001: Parameter WIDTH, default 12, coefficient width in bits (signed, two's complement).
REQ-002: Parameter N, default 8, block edge length; block holds N*N coefficients; N a power of two.
REQ-003: clk  input  1  sole clock; all state updates on rising edge.
REQ-004: rst  input  1  reset, synchronous, active-high.
REQ-005: ena_in  input  1  upstream data valid (driven by dct_1d ena_out).
REQ-006: a_in  input  WIDTH  signed coefficient, row-major order within block.
REQ-007: rdy_out  output  1  block can accept a_in this cycle (drives dct_1d rdy_in).
REQ-008: ena_out  output  1  S_out valid.
REQ-009: S_out  output  WIDTH  signed coefficient, column-major (transposed) order.
REQ-010: rdy_in  input  1  downstream accepts S_out this cycle.

Function
REQ-011: An input transfer SHALL occur on a rising edge with ena_in=1 and rdy_out=1; an output transfer SHALL occur on a rising edge with ena_out=1 and rdy_in=1.
REQ-012: Storage SHALL be register banks of N*N x WIDTH; each bank has state EMPTY, FILLING, FULL or DRAINING.
REQ-013: Write counter (row,col) SHALL advance col-fastest on each input transfer and wrap to (0,0) after (N-1,N-1); ena_in=0 holds it.
REQ-014: Read counter (col,row) SHALL advance row-fastest on each output transfer; S_out = bank[row][col] at the current read position.
REQ-015: Bank transitions: EMPTY->FILLING on first write; FILLING->FULL on N*N-th write; FULL->DRAINING when selected by reader; DRAINING->EMPTY on N*N-th read.
REQ-016: ena_out SHALL be 1 exactly when the read bank is FULL or DRAINING; first ena_out=1 SHALL be the cycle after the N*N-th input transfer (latency 1 cycle).
REQ-017: S_out SHALL be 0 whenever ena_out=0.
REQ-018: rdy_out SHALL be 1 exactly when the write bank is EMPTY or FILLING.
REQ-019: Coefficients SHALL pass bit-exact; no arithmetic, rounding or saturation.
REQ-020: ena_out=1 with rdy_in=0 SHALL hold S_out and read counter unchanged.
REQ-021: Simultaneous final write of one bank and final read of another in the same cycle SHALL apply both transitions; no transfer lost or duplicated.
REQ-022: Block boundaries SHALL be defined only by counter wrap; gaps in ena_in or rdy_in never reset counters.

Reset
REQ-023: rst=1 on a rising edge SHALL set all banks EMPTY, both counters (0,0), bank selectors to bank 0, regardless of operation in progress.
REQ-024: Cycle after reset: rdy_out=1, ena_out=0, S_out=0; bank contents need not be cleared.
REQ-025: Transfers presented in a cycle with rst=1 SHALL be ignored.

Configuration
REQ-026: Macro DCT_TRANSPOSE_PINGPONG_EN defined: two banks; writer fills one while reader drains the other; writer switches bank on FULL if other bank is EMPTY (or becomes EMPTY that cycle); sustained throughput one coefficient per cycle, rdy_out never drops with rdy_in=1.
REQ-027: Macro undefined: one bank; rdy_out=0 from the cycle after the N*N-th write until the cycle after the N*N-th read; throughput one block per 2*N*N cycles minimum.

Verification
REQ-028: Block a[r][c]=r*8+c, rdy_in=1 -> S_out sequence 0,8,16,...,56,1,9,...,63; ena_out rises cycle after 64th accept.
REQ-029: Same block, rdy_in toggling 1,0,1,0 -> identical 64-value sequence, S_out stable across rdy_in=0 cycles, no drop/duplicate.
REQ-030: Two back-to-back blocks, rdy_in=1 -> PINGPONG: rdy_out stays 1, 128 outputs contiguous; no macro: rdy_out=0 for 64 cycles between blocks.
REQ-031: ena_in=0 for 5 cycles after input index 11 -> output order unchanged, output starts cycle after 64th accept.
REQ-032: rst pulsed after 20 outputs -> next cycle ena_out=0, rdy_out=1, S_out=0; following block outputs from its transposed element 0.
REQ-033: Block of alternating -2048 and 2047 (WIDTH=12) -> values emerge unchanged in transposed order.

Source files
------------

// File: rtl/dct_transpose.sv
// Transpose buffer between the row and column 1-D DCT passes: coefficients enter row-major and leave column-major.
// Define DCT_TRANSPOSE_PINGPONG_EN for two banks (fill one while draining the other); otherwise one bank.
module dct_transpose #(
  parameter int WIDTH = 12,
  parameter int N     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena_in,
  input  logic signed [WIDTH-1:0] a_in,
  output logic                    rdy_out,
  output logic                    ena_out,
  output logic signed [WIDTH-1:0] S_out,
  input  logic                    rdy_in
);

`ifdef DCT_TRANSPOSE_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * CW;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_st_e;

  bank_st_e bank_st_q [NB];
  bank_st_e bank_st_d [NB];

  // Write position packs {row,col} and read position packs {col,row}; since N is a power
  // of two, a plain increment of each gives the col-fastest / row-fastest wrap order.
  logic [PW-1:0] wr_pos_q, wr_pos_d;
  logic [PW-1:0] rd_pos_q, rd_pos_d;
  logic          wsel_q, wsel_d;
  logic          rsel_q, rsel_d;

  logic signed [WIDTH-1:0] mem_q [NB][N*N];

  logic          wr_xfer, rd_xfer;
  logic          wr_last, rd_last;
  logic [PW-1:0] rd_idx;

  always_comb begin
    rdy_out = (bank_st_q[wsel_q] == EMPTY) || (bank_st_q[wsel_q] == FILLING);
    ena_out = (bank_st_q[rsel_q] == FULL)  || (bank_st_q[rsel_q] == DRAINING);
    rd_idx  = {rd_pos_q[CW-1:0], rd_pos_q[PW-1:CW]};
    S_out   = ena_out ? mem_q[rsel_q][rd_idx] : '0;
  end

  always_comb begin
    wr_xfer  = ena_in && rdy_out;
    rd_xfer  = ena_out && rdy_in;
    wr_last  = wr_xfer && (wr_pos_q == '1);
    rd_last  = rd_xfer && (rd_pos_q == '1);
    wr_pos_d = wr_xfer ? wr_pos_q + 1'b1 : wr_pos_q;
    rd_pos_d = rd_xfer ? rd_pos_q + 1'b1 : rd_pos_q;
    wsel_d   = wsel_q;
    rsel_d   = rsel_q;
    if (wr_last) wsel_d = (NB == 2) ? ~wsel_q : 1'b0;
    if (rd_last) rsel_d = (NB == 2) ? ~rsel_q : 1'b0;
    // Writer and reader never target the same bank in one cycle (their states are disjoint),
    // so a final write and a final read on different banks both take effect.
    for (int unsigned b = 0; b < NB; b++) begin
      bank_st_d[b] = bank_st_q[b];
      if (wr_xfer && (wsel_q == 1'(b))) bank_st_d[b] = wr_last ? FULL : FILLING;
      if (rd_xfer && (rsel_q == 1'(b))) bank_st_d[b] = rd_last ? EMPTY : DRAINING;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned b = 0; b < NB; b++) bank_st_q[b] <= EMPTY;
      wr_pos_q <= '0;
      rd_pos_q <= '0;
      wsel_q   <= 1'b0;
      rsel_q   <= 1'b0;
    end else begin
      for (int unsigned b = 0; b < NB; b++) bank_st_q[b] <= bank_st_d[b];
      wr_pos_q <= wr_pos_d;
      rd_pos_q <= rd_pos_d;
      wsel_q   <= wsel_d;
      rsel_q   <= rsel_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_xfer) mem_q[wsel_q][wr_pos_q] <= a_in;
  end

endmodule

// File: tb/tb_dct_transpose.sv
// Self-checking bench for dct_transpose (WIDTH=12, N=8): scenario table plus back-to-back and reset sequences.
module tb_dct_transpose;

  logic               clk = 1'b0;
  logic               rst;
  logic               ena_in;
  logic signed [11:0] a_in;
  logic               rdy_out;
  logic               ena_out;
  logic signed [11:0] S_out;
  logic               rdy_in;

  dct_transpose #(.WIDTH(12), .N(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena_in  (ena_in),
    .a_in    (a_in),
    .rdy_out (rdy_out),
    .ena_out (ena_out),
    .S_out   (S_out),
    .rdy_in  (rdy_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int stall_cycles = 0;
  int in_cnt = 0;
  bit tog_mode = 1'b0;
  logic signed [11:0] blk [64];
  logic signed [11:0] exp_q [$];

  typedef struct {
    int pattern;
    bit toggle;
    int gap_idx;
    int gap_len;
    bit exp_ena_after_last;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [11:0] gen(input int pattern, input int idx);
    logic signed [11:0] v;
    case (pattern)
      0:       v = 12'(idx);
      1:       v = (idx % 2 == 1) ? 12'sd2047 : -12'sd2048;
      default: v = 12'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    rdy_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy_in = tog_mode ? ~rdy_in : 1'b1;
    end
  end

  bit prev_stall = 1'b0;
  logic signed [11:0] prev_s;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else if (ena_out) begin
      if (prev_stall) chk("hold_S_out", int'(S_out), int'(prev_s));
      if (rdy_in) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          chk("data", int'(S_out), int'(exp_q.pop_front()));
          out_cnt++;
        end
      end
      prev_stall = !rdy_in;
      prev_s = S_out;
    end else begin
      chk("S_out_zero_when_idle", int'(S_out), 0);
      prev_stall = 1'b0;
    end
  end

  task automatic send(input logic signed [11:0] v);
    int unsigned t = 0;
    ena_in = 1'b1;
    a_in = v;
    @(negedge clk);
    while (!rdy_out && t < 500) begin
      @(negedge clk);
      t++;
    end
    stall_cycles += int'(t);
    if (!rdy_out) begin
      chk("accept_timeout", 0, 1);
      ena_in = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    ena_in = 1'b0;
    blk[in_cnt] = v;
    in_cnt++;
    if (in_cnt == 64) begin
      in_cnt = 0;
      for (int c = 0; c < 8; c++)
        for (int r = 0; r < 8; r++)
          exp_q.push_back(blk[r*8 + c]);
    end
  endtask

  task automatic drain();
    int unsigned t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    chk("drain_remaining", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int stall0;
    int base;
    int unsigned t;

    vecs[0] = '{pattern: 0, toggle: 1'b0, gap_idx: -1, gap_len: 0, exp_ena_after_last: 1'b1};
    vecs[1] = '{pattern: 0, toggle: 1'b1, gap_idx: -1, gap_len: 0, exp_ena_after_last: 1'b1};
    vecs[2] = '{pattern: 0, toggle: 1'b0, gap_idx: 11, gap_len: 5, exp_ena_after_last: 1'b1};
    vecs[3] = '{pattern: 1, toggle: 1'b0, gap_idx: -1, gap_len: 0, exp_ena_after_last: 1'b1};
    vecs[4] = '{pattern: 2, toggle: 1'b1, gap_idx: 30, gap_len: 3, exp_ena_after_last: 1'b1};

    rst = 1'b1;
    ena_in = 1'b0;
    a_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rdy_out", int'(rdy_out), 1);
    chk("reset_ena_out", int'(ena_out), 0);
    chk("reset_S_out", int'(S_out), 0);
    @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) begin
      tog_mode = vecs[v].toggle;
      for (int i = 0; i < 64; i++) begin
        if (i == 63) chk("ena_out_before_last", int'(ena_out), 0);
        send(gen(vecs[v].pattern, i));
        if (i == vecs[v].gap_idx) begin
          repeat (vecs[v].gap_len) @(posedge clk);
          #1;
        end
      end
      chk("ena_out_after_last", int'(ena_out), int'(vecs[v].exp_ena_after_last));
      drain();
      tog_mode = 1'b0;
      @(posedge clk);
      #1;
    end

    // Two back-to-back blocks with the downstream always ready.
    stall0 = stall_cycles;
    base = out_cnt;
    for (int i = 0; i < 128; i++) send(gen(2, i));
    drain();
`ifdef DCT_TRANSPOSE_PINGPONG_EN
    chk("b2b_rdy_out_low_cycles", stall_cycles - stall0, 0);
`else
    chk("b2b_rdy_out_low_cycles", stall_cycles - stall0, 64);
`endif
    chk("b2b_output_count", out_cnt - base, 128);

    // Reset in the middle of draining a block.
    base = out_cnt;
    for (int i = 0; i < 64; i++) send(gen(0, i));
    t = 0;
    while (out_cnt - base < 20 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("outputs_before_reset", int'(out_cnt - base >= 20), 1);
    #1;
    rst = 1'b1;
    ena_in = 1'b1;
    a_in = 12'sd99;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ena_in = 1'b0;
    exp_q.delete();
    in_cnt = 0;
    @(negedge clk);
    chk("midreset_rdy_out", int'(rdy_out), 1);
    chk("midreset_ena_out", int'(ena_out), 0);
    chk("midreset_S_out", int'(S_out), 0);
    @(posedge clk);
    #1;
    base = out_cnt;
    for (int i = 0; i < 64; i++) send(gen(2, i));
    drain();
    chk("post_reset_output_count", out_cnt - base, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
